// File: rtl/sys_bus.sv
// sys_bus: address decoder and interconnect between the 6502 core and system memory.
// Decodes RAM, ROM and an I/O page, aligns read data with 1-cycle memories, owns the debug FIFO port.
module sys_bus #(
    parameter int         RAM_AW     = 14,
    parameter int         ROM_AW     = 15,
    parameter logic [7:0] IO_PAGE    = 8'h40,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       addr_i,
    input  logic [7:0]        data_w_i,
    input  logic              we_i,
    output logic [7:0]        data_r_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_rdata_i,
    output logic [7:0]        dport_out_o,
    output logic              dport_write_o,
    input  logic              dport_ready_i,
    output logic              done_o
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [16:0] ROM_BASE = 17'h10000 - (17'd1 << ROM_AW);
    localparam logic [16:0] RAM_TOP  = 17'd1 << RAM_AW;
    localparam logic [4:0]  DEPTH5   = 5'(FIFO_DEPTH);

    localparam logic [1:0] REGION_NONE = 2'd0;
    localparam logic [1:0] REGION_RAM  = 2'd1;
    localparam logic [1:0] REGION_ROM  = 2'd2;
    localparam logic [1:0] REGION_IO   = 2'd3;

    logic          romHit, ioHit, ramHit, ioWe;
    logic          pushReq, pop, pushOk, drop, empty, full;
    logic          doneSet, dropsClr;
    logic [1:0]    region_d, region_q;
    logic [7:0]    ioRdata_d, ioRdata_q;
    logic [4:0]    count_d, count_q;
    logic [PW-1:0] rdPtr_q, wrPtr_q;
    logic [7:0]    lastData_q, drops_q;
    logic          done_q;
    logic [7:0]    mem [FIFO_DEPTH];

    // ROM wins over IO, IO over RAM, so overlapping parameter choices stay well defined
    assign romHit = ({1'b0, addr_i} >= ROM_BASE);
    assign ioHit  = !romHit && (addr_i[15:8] == IO_PAGE);
    assign ramHit = !romHit && !ioHit && ({1'b0, addr_i} < RAM_TOP);
    assign ioWe   = we_i && ioHit;

    assign ram_we_o    = we_i && ramHit;
    assign ram_addr_o  = addr_i[RAM_AW-1:0];
    assign ram_wdata_o = data_w_i;
    assign rom_addr_o  = addr_i[ROM_AW-1:0];

    assign empty    = (count_q == 5'd0);
    assign full     = (count_q == DEPTH5);
    assign pop      = dport_write_o && dport_ready_i;
    assign pushReq  = ioWe && (addr_i[7:0] == 8'h00);
    assign pushOk   = pushReq && (!full || pop);
    assign drop     = pushReq && full && !pop;
    assign doneSet  = ioWe && (addr_i[7:0] == 8'h02);
    assign dropsClr = ioWe && (addr_i[7:0] == 8'h03);
    assign count_d  = count_q + {4'b0, pushOk} - {4'b0, pop};

    assign dport_write_o = !empty;
    assign dport_out_o   = mem[rdPtr_q];
    assign done_o        = done_q;

    always_comb begin
        region_d = REGION_NONE;
        if (romHit) begin
            region_d = REGION_ROM;
        end else if (ioHit) begin
            region_d = REGION_IO;
        end else if (ramHit) begin
            region_d = REGION_RAM;
        end
    end

    always_comb begin
        ioRdata_d = 8'h00;
        case (addr_i[7:0])
            8'h00:   ioRdata_d = lastData_q;
            8'h01:   ioRdata_d = {done_q, full, empty, count_q};
            8'h02:   ioRdata_d = {7'b0, done_q};
            8'h03:   ioRdata_d = drops_q;
            default: ioRdata_d = 8'h00;
        endcase
    end

    // RAM/ROM data already arrives one cycle late, so only the region select needs delaying
    always_comb begin
        data_r_o = 8'h00;
        case (region_q)
            REGION_RAM: data_r_o = ram_rdata_i;
            REGION_ROM: data_r_o = rom_rdata_i;
            REGION_IO:  data_r_o = ioRdata_q;
            default:    data_r_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            region_q   <= REGION_NONE;
            ioRdata_q  <= 8'h00;
            count_q    <= 5'd0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            lastData_q <= 8'h00;
            drops_q    <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            region_q  <= region_d;
            ioRdata_q <= ioRdata_d;
            count_q   <= count_d;
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (pushOk) begin
                wrPtr_q    <= wrPtr_q + PW'(1);
                lastData_q <= data_w_i;
            end
            if (doneSet) begin
                done_q <= 1'b1;
            end
            if (dropsClr) begin
                drops_q <= 8'h00;
            end else if (drop && (drops_q != 8'hFF)) begin
                drops_q <= drops_q + 8'd1;
            end
        end
    end

    // Storage has no reset: stale bytes are hidden because the cleared count drops dport_write
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem[wrPtr_q] <= data_w_i;
        end
    end
endmodule
